program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  asynchronous, active-low (0 = reset).
REQ-004 Port: load_req  input  1  start a new load session; sampled only in IDLE, DONE, ERROR.
REQ-005 Port: byte_in  input  8  incoming program byte.
REQ-006 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-007 Port: byte_ready  output  1  loader accepts a byte; transfer occurs on byte_valid & byte_ready.
REQ-008 Port: en_write  output  1  instruction-memory write strobe.
REQ-009 Port: im_address  output  10  instruction-memory word address.
REQ-010 Port: data_out  output  16  instruction word to write.
REQ-011 Port: cpu_reset  output  1  active-high processor reset hold.
REQ-012 Port: start  output  1  one-cycle pulse to the control unit.
REQ-013 Port: busy / done / error  output  1 each  session status.

Function
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, START, DONE, ERROR.
REQ-015 The byte stream SHALL be: length high byte, length low byte, then 2*N data bytes, each word high byte first.
REQ-016 byte_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
REQ-017 load_req=1 in IDLE, DONE or ERROR SHALL move to LEN_HI next cycle, clear the word index, done and error; load_req in any other state SHALL be ignored.
REQ-018 After LEN_LO, N=0 or N>1024 SHALL go to ERROR; otherwise go to DATA_HI.
REQ-019 Accepting the DATA_LO byte SHALL go to WRITE; WRITE SHALL last exactly one cycle with en_write=1, im_address=word index, data_out={hi,lo}.
REQ-020 After WRITE the word index SHALL increment; if the index equals N go to CHECK (macro defined) or START, else go to DATA_HI.
REQ-021 Word index 1023 write followed by N=1024 SHALL terminate without the 10-bit im_address wrapping to 0 for an extra write.
REQ-022 START SHALL last one cycle with start=1 and cpu_reset=0, then go to DONE.
REQ-023 cpu_reset SHALL be 1 in every state except START and DONE.
REQ-024 DONE SHALL hold done=1, busy=0, cpu_reset=0 until load_req.
REQ-025 ERROR SHALL hold error=1, busy=0, cpu_reset=1, no start, until load_req.
REQ-026 busy SHALL be 1 in LEN_HI through START.
REQ-027 Throughput SHALL be 3 cycles per word with byte_valid held at 1; byte_valid gaps SHALL only stall, never corrupt.
REQ-028 en_write and start SHALL never be asserted in the same cycle.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, byte_ready=0, en_write=0, im_address=0, data_out=0, cpu_reset=1, start=0, busy=0, done=0, error=0, and clear the checksum and word index.
REQ-030 Reset mid-session SHALL abandon the session with no further en_write.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined, a trailing byte SHALL be accepted in CHECK; it equals the XOR of all preceding bytes including the length bytes. A match SHALL go to START; a mismatch SHALL go to ERROR.
REQ-032 Without LOADER_CHECKSUM_EN, CHECK SHALL be unreachable, WRITE of the last word SHALL go directly to START, and no checksum register SHALL exist.

Structure
REQ-033 The shared package loader_pkg SHALL hold the state encoding, IM_ADDR_W=10, MAX_WORDS=1024 and the length field width.
REQ-034 A sub-module loader_word_assembler (hi/lo byte pairing into 16 bits) is natural and SHALL be used if any sub-module is split out.

Verification
REQ-035 Bytes 00 02 40 04 70 00 (no checksum) -> en_write at addresses 0 and 1 with 4004h and 7000h, one start pulse, then done=1.
REQ-036 Length bytes 00 00 -> error=1, no en_write, cpu_reset stays 1.
REQ-037 Length 04 01 (1025) -> error=1; a following load_req with valid stream -> normal completion.
REQ-038 Random byte_valid gaps on a 15-word program -> identical writes, exactly 15 en_write pulses.
REQ-039 reset=0 asserted during DATA_LO of word 3 -> all outputs at reset values immediately, no further en_write.
REQ-040 With LOADER_CHECKSUM_EN, stream 00 01 FF FF and checksum 01 -> start pulse; checksum 00 -> error=1, no start.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encoding for program_loader
// Purpose: state encoding, address/length/word widths and the length
//          range check used by program_loader and its sub-module.
// Ports:   none (package).
package loader_pkg;

  localparam int IM_ADDR_W = 10;
  localparam int LEN_W     = 16;   // length field as carried on the byte stream
  localparam int IDX_W     = 11;   // must reach MAX_WORDS itself, one past the last address
  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 16;
  localparam int STATE_W   = 4;

  localparam logic [LEN_W-1:0] MAX_WORDS = 16'd1024;

  localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] ST_LEN_HI  = 4'd1;
  localparam logic [STATE_W-1:0] ST_LEN_LO  = 4'd2;
  localparam logic [STATE_W-1:0] ST_DATA_HI = 4'd3;
  localparam logic [STATE_W-1:0] ST_DATA_LO = 4'd4;
  localparam logic [STATE_W-1:0] ST_WRITE   = 4'd5;
  localparam logic [STATE_W-1:0] ST_CHECK   = 4'd6;
  localparam logic [STATE_W-1:0] ST_START   = 4'd7;
  localparam logic [STATE_W-1:0] ST_DONE    = 4'd8;
  localparam logic [STATE_W-1:0] ST_ERROR   = 4'd9;

  // A program must hold at least one word and fit in instruction memory.
  function automatic logic len_valid(input logic [LEN_W-1:0] n);
    return (n != '0) && (n <= MAX_WORDS);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - pairs high/low program bytes into one 16-bit word
// Purpose: captures the high byte then the low byte of an instruction word.
// Ports:   clk      - rising-edge clock
//          reset    - asynchronous active-low reset, clears both halves
//          hi_we    - capture byte_in as the high byte
//          lo_we    - capture byte_in as the low byte
//          byte_in  - incoming program byte
//          word     - assembled word {high, low}
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= byte_in;
      if (lo_we) lo_q <= byte_in;
    end
  end

  assign word = {hi_q, lo_q};

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream instruction-memory loader with CPU reset/start control
// Purpose: receives a length-prefixed program over a byte stream, writes each
//          16-bit word to instruction memory, then releases the CPU with a
//          one-cycle start pulse. Define LOADER_CHECKSUM_EN to require a
//          trailing XOR checksum byte before the CPU is started.
// Ports:   clk        - rising-edge system clock
//          reset      - asynchronous active-low reset
//          load_req   - begin a new session (honoured in IDLE, DONE, ERROR)
//          byte_in    - program byte
//          byte_valid - byte_in holds a valid byte
//          byte_ready - loader accepts a byte this cycle
//          en_write   - instruction-memory write strobe
//          im_address - instruction-memory word address
//          data_out   - instruction word to write
//          cpu_reset  - active-high processor reset hold
//          start      - one-cycle pulse to the control unit
//          busy/done/error - session status
module program_loader
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_req,
  input  logic [BYTE_W-1:0]    byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 en_write,
  output logic [IM_ADDR_W-1:0] im_address,
  output logic [WORD_W-1:0]    data_out,
  output logic                 cpu_reset,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_inc;
  logic               xfer;
  logic               idle_like;
  logic               session_start;
  logic               last_word;
  logic [WORD_W-1:0]  word;

  assign xfer          = byte_valid & byte_ready;
  assign idle_like     = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign session_start = load_req & idle_like;
  assign idx_inc       = idx_q + IDX_W'(1);
  // Compared on the incremented index so word 1023 with N=1024 ends the
  // session instead of letting the 10-bit address wrap to 0.
  assign last_word     = (LEN_W'(idx_inc) == len_q);

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
  logic              csum_ok;

  assign csum_ok = (byte_in == csum_q);

  // Running XOR of every accepted byte before the trailing checksum byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (session_start) begin
      csum_q <= '0;
    end else if (xfer && (state_q != ST_CHECK)) begin
      csum_q <= csum_q ^ byte_in;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_req) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (xfer) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) state_d = len_valid({len_q[LEN_W-1:BYTE_W], byte_in}) ? ST_DATA_HI : ST_ERROR;
      end
      ST_DATA_HI: begin
        if (xfer) state_d = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        if (xfer) state_d = ST_WRITE;
      end
      ST_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = last_word ? ST_CHECK : ST_DATA_HI;
`else
        state_d = last_word ? ST_START : ST_DATA_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) state_d = csum_ok ? ST_START : ST_ERROR;
      end
`endif
      ST_START: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (session_start) begin
        idx_q <= '0;
      end else if (state_q == ST_WRITE) begin
        idx_q <= idx_inc;
      end
      if (xfer && (state_q == ST_LEN_HI)) len_q[LEN_W-1:BYTE_W] <= byte_in;
      if (xfer && (state_q == ST_LEN_LO)) len_q[BYTE_W-1:0]     <= byte_in;
    end
  end

  loader_word_assembler u_word_asm (
    .clk     (clk),
    .reset   (reset),
    .hi_we   (xfer && (state_q == ST_DATA_HI)),
    .lo_we   (xfer && (state_q == ST_DATA_LO)),
    .byte_in (byte_in),
    .word    (word)
  );

  // All outputs decode from the state register, so the asynchronous reset
  // drives them to their idle values without waiting for a clock edge.
  assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                      (state_q == ST_CHECK);
  assign en_write   = (state_q == ST_WRITE);
  assign im_address = idx_q[IM_ADDR_W-1:0];
  assign data_out   = word;
  assign start      = (state_q == ST_START);
  assign cpu_reset  = !((state_q == ST_START) || (state_q == ST_DONE));
  assign busy       = !idle_like;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        en_write;
  logic [9:0]  im_address;
  logic [15:0] data_out;
  logic        cpu_reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .en_write   (en_write),
    .im_address (im_address),
    .data_out   (data_out),
    .cpu_reset  (cpu_reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Observed memory writes {address, data}, their cycle stamps, start pulses.
  logic [25:0] obs_w[$];
  int          obs_t[$];
  int          start_cnt = 0;
  int          overlap_cnt = 0;

  always @(negedge clk) begin
    if (en_write) begin
      obs_w.push_back({im_address, data_out});
      obs_t.push_back(cycle);
    end
    if (start) start_cnt++;
    if (en_write && start) overlap_cnt++;
  end

  // Stream under test and the reference expectations derived from it.
  logic [7:0]  stream[$];
  logic [25:0] exp_w[$];
  bit          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic append_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (stream[k]) x ^= stream[k];
    stream.push_back(x);
`endif
  endtask

  // Length-prefixed program of random words; checksum added only for lengths
  // the loader will accept.
  task automatic build(input int len, input int nwords);
    logic [31:0] w;
    stream.delete();
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    for (int i = 0; i < nwords; i++) begin
      w = $urandom;
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
    if (len >= 1 && len <= 1024) append_csum();
  endtask

  // Reference: word i of the stream lands at address i; bad lengths write nothing.
  task automatic model();
    int n;
    exp_w.delete();
    n = int'({stream[0], stream[1]});
    exp_err = (n == 0) || (n > 1024);
    if (!exp_err) begin
      for (int i = 0; i < n; i++)
        exp_w.push_back({10'(i), stream[2 + 2 * i], stream[3 + 2 * i]});
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 2 + 2 * n; k++) x ^= stream[k];
        if (x != stream[2 + 2 * n]) exp_err = 1'b1;
      end
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
    int g;
    int waitc;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      load_req   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    load_req   = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    waitc      = 0;
    while (!byte_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    ok = byte_ready;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({byte_ready, en_write, cpu_reset, start, busy, done, error}), 32'h10);
    chk({tag, "_addr"}, 32'(im_address), 32'h0);
    chk({tag, "_data"}, 32'(data_out), 32'h0);
  endtask

  task automatic run_session(input string tag, input int gap_max);
    bit ok;
    bit all_ok;
    int w;
    int bad;
    model();
    obs_w.delete();
    obs_t.delete();
    start_cnt = 0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk({tag, "_busy_at_start"}, 32'({busy, done, error}), 32'h4);
    all_ok = 1'b1;
    foreach (stream[k]) begin
      send_byte(stream[k], gap_max, ok);
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
    end
    chk({tag, "_all_bytes_accepted"}, 32'(all_ok), 32'h1);
    w = 0;
    while (!done && !error && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
    chk({tag, "_busy_end"}, 32'({busy, byte_ready}), 32'h0);
    chk({tag, "_start_pulses"}, 32'(start_cnt), exp_err ? 32'h0 : 32'h1);
    chk({tag, "_write_count"}, 32'(obs_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(obs_w[i]), 32'(exp_w[i]));
    if (gap_max == 0 && obs_t.size() > 1) begin
      bad = 0;
      for (int i = 1; i < obs_t.size(); i++)
        if (obs_t[i] - obs_t[i - 1] != 3) bad++;
      chk({tag, "_three_cycles_per_word"}, 32'(bad), 32'h0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({busy, done, error, cpu_reset, byte_ready}), 32'h2);

    // Two-word program with fixed contents.
    stream = '{8'h00, 8'h02, 8'h40, 8'h04, 8'h70, 8'h00};
    append_csum();
    run_session("basic", 0);
    chk("basic_w0_const", obs_w.size() > 0 ? 32'(obs_w[0]) : 32'hFFFF_FFFF, 32'h0000_4004);
    chk("basic_w1_const", obs_w.size() > 1 ? 32'(obs_w[1]) : 32'hFFFF_FFFF, 32'h0001_7000);

    // Zero length.
    stream = '{8'h00, 8'h00};
    run_session("len0", 0);

    // Oversized length, then recovery with a valid program.
    build(1025, 0);
    run_session("len1025", 0);
    build(5, 5);
    run_session("after_error", 0);

    // Fifteen words, back-to-back and with random gaps (load_req noise inside gaps).
    build(15, 15);
    run_session("w15_nogap", 0);
    run_session("w15_gaps", 3);
    chk("w15_gaps_pulses", 32'(obs_w.size()), 32'd15);

    // Reset while waiting for the low byte of word 3.
    build(10, 10);
    obs_w.delete();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    for (int k = 0; k < 9; k++) send_byte(stream[k], 0, ok);
    chk("abort_in_data_lo", 32'({byte_ready, busy, en_write}), 32'h6);
    chk("abort_writes_before", 32'(obs_w.size()), 32'd3);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    byte_valid = 1'b1;
    repeat (4) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    reset = 1'b1;
    repeat (12) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("abort_no_more_writes", 32'(obs_w.size()), 32'd3);
    chk("abort_idle", 32'({busy, done, error, cpu_reset, byte_ready}), 32'h2);

    build(3, 3);
    run_session("post_reset", 0);

    // Smallest and largest legal programs.
    build(1, 1);
    run_session("n1", 2);
    build(1024, 1024);
    run_session("n1024", 0);
    chk("n1024_last_addr", obs_w.size() > 0 ? 32'(obs_w[obs_w.size() - 1][25:16]) : 32'hFFFF_FFFF, 32'd1023);

`ifdef LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h01};
    run_session("csum_match", 0);
    stream = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00};
    run_session("csum_mismatch", 0);
`else
    stream = '{8'h00, 8'h01, 8'hFF, 8'hFF};
    run_session("n1_ffff", 0);
`endif

    chk("no_write_start_overlap", 32'(overlap_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
